// File: rtl/sodor_tb_pkg.sv
// Shared definitions for the Sodor stimulus sequencers: opcodes, modes, LFSR taps
// and the RV32I instruction encoder used to turn LFSR state into a stream word.
package sodor_tb_pkg;

  localparam logic [6:0]  OP_RTYPE  = 7'h33;
  localparam logic [6:0]  OP_ITYPE  = 7'h13;
  localparam logic [6:0]  OP_LOAD   = 7'h03;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    MODE_RTYPE = 2'd0,
    MODE_ITYPE = 2'd1,
    MODE_LOAD  = 2'd2,
    MODE_MIXED = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic logic [31:0] lfsr32_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [31:0] encode_instr(input mode_e m, input logic [31:0] s);
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [11:0] imm;
    mode_e       cls;
    logic [31:0] word;
    rd   = s[4:0];
    rs1  = s[9:5];
    rs2  = s[14:10];
    f3   = s[17:15];
    f7b5 = s[18];
    imm  = s[30:19];
    cls  = m;
    if (m == MODE_MIXED) begin
      case (s[31:30])
        2'd2:    cls = MODE_ITYPE;
        2'd3:    cls = MODE_LOAD;
        default: cls = MODE_RTYPE;
      endcase
    end
    case (cls)
      MODE_ITYPE: begin
        // Shift-immediates only allow shamt, plus bit 30 for SRAI.
        if (f3 == 3'd1)      imm = imm & 12'h01F;
        else if (f3 == 3'd5) imm = imm & 12'h41F;
        word = {imm, rs1, f3, rd, OP_ITYPE};
      end
      MODE_LOAD: word = {imm, rs1, f3 & 3'b100, rd, OP_LOAD};
      default:   word = {1'b0, f7b5 && (f3 == 3'd0 || f3 == 3'd5), 5'd0,
                         rs2, rs1, f3, rd, OP_RTYPE};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/sodor_lfsr32.sv
// 32-bit right-shifting Galois LFSR with a load port and a single-cycle step.
module sodor_lfsr32
  import sodor_tb_pkg::*;
(
  input  logic        clk,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // A zero seed would lock the register up, so it is replaced by 1.
  always_comb begin
    state_d = state_q;
    if (load_i)      state_d = (seed_i == 32'd0) ? 32'd1 : seed_i;
    else if (step_i) state_d = lfsr32_next(state_q);
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/sodor_instr_sequencer.sv
// Started, counted, flow-controlled RV32I stimulus stream with a NOP drain tail
// so core and reference model can be compared at a clean boundary.
module sodor_instr_sequencer
  import sodor_tb_pkg::*;
#(
  parameter logic [31:0] SEED         = 32'd180,
  parameter int unsigned NUM_INSTR    = 100,
  parameter int unsigned DRAIN_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [15:0] issued_count,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LAST_INSTR = 16'(NUM_INSTR - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(DRAIN_CYCLES - 1);

  seq_state_e  state_q;
  mode_e       mode_q;
  logic [15:0] cnt_q;
  logic [15:0] drain_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] lfsr_s;
  logic        accept;

  assign instr_valid = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign instr       = (state_q == ST_RUN) ? encode_instr(mode_q, lfsr_s) : NOP_INSTR;
  assign accept      = instr_valid && instr_ready;

  // The generator only moves on an accepted random word, so stalls hold instr.
  sodor_lfsr32 u_lfsr (
    .clk     (clk),
    .load_i  (reset),
    .seed_i  (SEED),
    .step_i  (accept && (state_q == ST_RUN)),
    .state_o (lfsr_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_RTYPE;
      cnt_q   <= 16'd0;
      drain_q <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            mode_q  <= mode_e'(mode);
            cnt_q   <= 16'd0;
            drain_q <= 16'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == LAST_INSTR) begin
              state_q <= ST_DRAIN;
              drain_q <= 16'd0;
            end
          end
        end
        ST_DRAIN: begin
          if (accept) begin
            if (drain_q == LAST_DRAIN) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              drain_q <= drain_q + 16'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign issued_count = cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: doc/sodor_instr_sequencer.md
# sodor_instr_sequencer

Constrained-random instruction sequencer for the Sodor 5-stage verification harness. It replaces free-running per-cycle stimulus with a started, counted, flow-controlled stream of RV32I instructions (R-type ALU, I-type ALU, loads, or a mix) feeding the core's instruction-response port. After the programmed count it drains the pipeline with NOPs and signals completion, so the co-simulated model and RTL core can be compared at a clean boundary.

## Interface
- `SEED`, 180: initial LFSR state; a value of 0 is replaced by 1.
- `NUM_INSTR`, 100: random instructions per run; range 1..65535.
- `DRAIN_CYCLES`, 5: NOPs issued after the last random instruction; matches pipeline depth.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset; synchronous and active-high.
- `start` in 1: begin a run; honoured only in IDLE or DONE.
- `mode` in 2: instruction class, sampled at `start`; 0 R-type, 1 I-type ALU, 2 load, 3 mixed.
- `instr_ready` in 1: consumer accepts `instr` this cycle.
- `instr_valid` out 1: `instr` holds a stream word.
- `instr` out 32: instruction word.
- `issued_count` out 16: random instructions accepted in the current run.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: high in DONE.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE (2-bit encoding).
- **IDLE / DONE:**
  - `instr` = 32'h00000013 (NOP), `instr_valid` = 0.
  - `start` → RUN next cycle; clear `issued_count`; latch `mode`.
  - The LFSR is not reseeded on a restart; the stream continues.
- **RUN:**
  - `instr_valid` = 1; `instr` is built combinationally from the LFSR state `s`.
  - On `instr_valid && instr_ready`: advance the LFSR and increment `issued_count`.
  - On the accept where `issued_count` becomes `NUM_INSTR`: go to DRAIN.
- **DRAIN:**
  - `instr` = NOP, `instr_valid` = 1.
  - A drain counter counts accepted NOPs; after `DRAIN_CYCLES` accepts, go to DONE.
- **LFSR:** 32-bit Galois, right-shift.
  - Next state: if `s[0]`, `(s>>1) ^ 32'h80200003`; else `s>>1`.
  - It never reaches 0.
- **Field map:** `rd=s[4:0]`, `rs1=s[9:5]`, `rs2=s[14:10]`, `f3=s[17:15]`, `f7b5=s[18]`, `imm=s[30:19]`.
  - Mixed-mode class from `s[31:30]`: 0 or 1 R-type, 2 I-type, 3 load.
- **R-type:** `{1'b0, f7b5', 5'd0, rs2, rs1, f3, rd, 7'h33}`.
  - `f7b5' = f7b5` only when `f3` is 0 or 5, otherwise 0.
- **I-type ALU:** `{imm', rs1, f3, rd, 7'h13}`.
  - `f3==1`: `imm' = imm & 12'h01F`.
  - `f3==5`: `imm' = imm & 12'h41F`.
  - Otherwise `imm' = imm`.
- **Load:** `{imm, rs1, f3 & 3'b100, rd, 7'h03}`.
- **Stability:** while `instr_valid && !instr_ready`, `instr` holds and neither the LFSR nor any counter changes.
- **Ignored `start`:** `start` in RUN or DRAIN has no effect.

## Timing
- **Reset values:**
  - state IDLE, LFSR = `SEED` (or 1 if `SEED` is 0).
  - `issued_count` = 0, drain counter = 0.
  - `instr_valid` = 0, `instr` = NOP, `busy` = 0, `done` = 0.
- **Start latency:** `start` sampled at edge N; first valid word visible after edge N, in cycle N+1.
- **Run length:** with `instr_ready` tied high, a run lasts `NUM_INSTR + DRAIN_CYCLES` valid cycles, then `done` rises.
- **Back-to-back:** `start` asserted in the same cycle `done` is high is honoured.
- **Reset mid-run:** returns to the reset state on the next edge.
  - `instr_valid` drops and `issued_count` clears.
  - The LFSR reloads `SEED`.
- **Counter width:** `issued_count` does not wrap within the allowed `NUM_INSTR` range.
- **Registered outputs:** `busy`, `done` and `issued_count` are registered. `instr` and `instr_valid` are combinational from registered state only.

## Structure
- **Shared package `sodor_tb_pkg`:**
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD.
  - `NOP_INSTR`.
  - mode enum.
  - LFSR tap constant `32'h80200003`.
- **Sub-module `sodor_lfsr32`:**
  - load / step interface, single-cycle step.
  - reused by other stimulus sequencers.
- Instruction encoding is a function in the package, not a module.

## Test plan
- **Basic R-type run:** `SEED`=1, `mode`=0, `NUM_INSTR`=2, ready high, pulse `start`.
  - First word 32'h000000B3 (add x1,x0,x0), second 32'h000001B3.
  - Then 5 NOPs, then `done`=1, `issued_count`=2.
- **Backpressure:** hold `instr_ready` low 3 cycles mid-RUN.
  - `instr` is unchanged across the stall and `issued_count` is frozen.
  - Total accepted words still equals `NUM_INSTR`.
- **I-type immediate masks:** `mode`=1, 1000 instructions.
  - Every `f3==1` word has `instr[31:25]==0`.
  - Every `f3==5` word has `instr[31:25]` of 0x00 or 0x20.
- **Load class:** `mode`=2.
  - Every word has opcode 7'h03 and `instr[13:12]==0`.
- **Reset mid-run:** assert `reset` at `issued_count`=40.
  - Next cycle `instr_valid`=0, `issued_count`=0, `busy`=0.
  - A fresh `start` reproduces the original first word.
- **Ignored `start` and restart:** pulse `start` during DRAIN, and again in the cycle `done` is high.
  - The DRAIN pulse has no effect.
  - The second pulse starts a new run in the next cycle, continuing the LFSR sequence.
